alu_wide_sequencer: RTL and testbench

Two-pass sequencer that executes 64-bit AND/OR/ADD/SUB commands on the team's 32-bit combinational ALU. Sits directly upstream of the ALU: accepts a command over a valid/ready handshake, drives the ALU's Operation/Binvert/CarryIn/a/b for a low-half pass, then a high-half pass, and chains the ALU's CarryOut between passes. Returns the 64-bit result plus carry, zero and signed-overflow flags over a second valid/ready handshake.

---
 rtl/alu_wide_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_wide_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer.sv
// rtl/alu_wide_sequencer.sv - two-pass 64-bit AND/OR/ADD/SUB sequencer over a 32-bit combinational ALU
module alu_wide_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_operation,
  output logic        alu_carry_in,
  output logic        alu_binvert,
  input  logic [31:0] alu_result,
  input  logic        alu_carry_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_carry,
  output logic        out_zero,
  output logic        out_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_op;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [31:0] r_res_lo;
  logic [31:0] r_res_hi;
  logic        r_carry_q;
  logic        r_carry;
  logic        r_zero;
  logic        r_overflow;

  logic        w_is_arith;
  logic        w_is_sub;
  logic        w_bh;
  logic        w_overflow;
  logic        w_zero;

  assign w_is_arith = r_op[1];
  assign w_is_sub   = (r_op == 2'b11);

  // Effective sign of the second addend: SUB adds ~b, so its sign bit is inverted.
  assign w_bh       = w_is_sub ? ~r_b[63] : r_b[63];
  assign w_overflow = w_is_arith && (r_a[63] == w_bh) && (alu_result[31] != r_a[63]);
  assign w_zero     = ({alu_result, r_res_lo} == 64'd0);

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign out_valid  = (r_state == S_DONE);
  assign out_result = {r_res_hi, r_res_lo};
  assign out_carry    = r_carry;
  assign out_zero     = r_zero;
  assign out_overflow = r_overflow;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: accept in IDLE, two fixed passes, hold DONE until the consumer takes it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_LO;
      S_LO:   w_next = S_HI;
      S_HI:   w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ALU drive: lower the 64-bit op into one 32-bit pass per half; idle ALU inputs are zero.
  always_comb begin
    alu_a         = 32'd0;
    alu_b         = 32'd0;
    alu_operation = 2'b00;
    alu_carry_in  = 1'b0;
    alu_binvert   = 1'b0;
    case (r_state)
      S_LO: begin
        alu_a         = r_a[31:0];
        alu_b         = r_b[31:0];
        alu_operation = w_is_arith ? 2'b10 : r_op;
        alu_binvert   = w_is_sub;
        alu_carry_in  = w_is_sub;
      end
      S_HI: begin
        alu_a         = r_a[63:32];
        alu_b         = r_b[63:32];
        alu_operation = w_is_arith ? 2'b10 : r_op;
        alu_binvert   = w_is_sub;
        alu_carry_in  = w_is_arith & r_carry_q;
      end
      default: ;
    endcase
  end

  // Datapath: capture command on acceptance, collect each half, and latch flags after the high pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= 2'b00;
      r_a        <= 64'd0;
      r_b        <= 64'd0;
      r_res_lo   <= 32'd0;
      r_res_hi   <= 32'd0;
      r_carry_q  <= 1'b0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op <= in_op;
          r_a  <= in_a;
          r_b  <= in_b;
        end
        S_LO: begin
          r_res_lo  <= alu_result;
          r_carry_q <= alu_carry_out;
        end
        S_HI: begin
          r_res_hi   <= alu_result;
          r_carry    <= w_is_arith & alu_carry_out;
          r_zero     <= w_zero;
          r_overflow <= w_overflow;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb/tb_alu_wide_sequencer.sv - directed self-checking bench for alu_wide_sequencer
module tb_alu_wide_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_operation;
  logic        alu_carry_in;
  logic        alu_binvert;
  logic [31:0] alu_result;
  logic        alu_carry_out;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic        out_overflow;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  always #5 clk = ~clk;

  alu_wide_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_carry_in(alu_carry_in), .alu_binvert(alu_binvert),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_overflow(out_overflow)
  );

  // Behavioural model of the 32-bit combinational ALU the sequencer drives.
  logic [31:0] m_bb;
  logic [32:0] m_sum;
  always_comb begin
    m_bb  = alu_binvert ? ~alu_b : alu_b;
    m_sum = {1'b0, alu_a} + {1'b0, m_bb} + {32'd0, alu_carry_in};
    case (alu_operation)
      2'b00:   alu_result = alu_a & m_bb;
      2'b01:   alu_result = alu_a | m_bb;
      default: alu_result = m_sum[31:0];
    endcase
    alu_carry_out = m_sum[32];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge where the sequencer is idle, follow it through both
  // passes, hold the result for 'hold' cycles while a second command is offered, then retire.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res, input logic exp_c,
                         input logic exp_z, input logic exp_v, input logic exp_hi_cin,
                         input int hold);
    int lat;
    logic [63:0] held;
    chk({tag, " in_ready idle"}, {63'd0, in_ready}, 64'd1);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_op = ~op;
        chk({tag, " lo alu_a"}, {32'd0, alu_a}, {32'd0, a[31:0]});
        chk({tag, " lo cin"}, {63'd0, alu_carry_in}, {63'd0, (op == OP_SUB)});
        chk({tag, " lo binv"}, {63'd0, alu_binvert}, {63'd0, (op == OP_SUB)});
      end
      if (lat == 2) begin
        chk({tag, " hi alu_a"}, {32'd0, alu_a}, {32'd0, a[63:32]});
        chk({tag, " hi cin"}, {63'd0, alu_carry_in}, {63'd0, exp_hi_cin});
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'd3);
    chk({tag, " result"}, out_result, exp_res);
    chk({tag, " flags c/z/v"}, {61'd0, out_carry, out_zero, out_overflow},
        {61'd0, exp_c, exp_z, exp_v});
    chk({tag, " alu idle"}, {30'd0, alu_operation, alu_a}, 64'd0);
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_op = OP_ADD; in_a = 64'd2; in_b = 64'd3;
      @(negedge clk);
      chk({tag, " held result"}, out_result, held);
      chk({tag, " held valid/ready"}, {62'd0, out_valid, in_ready}, 64'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " retire valid/ready"}, {62'd0, out_valid, in_ready}, 64'd1);
    if (hold == 0) in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = 64'd0; in_b = 64'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_result", out_result, 64'd0);
    chk("reset flags", {61'd0, out_carry, out_zero, out_overflow}, 64'd0);
    chk("reset alu", {alu_a, alu_b}, 64'd0);
    chk("reset alu ctl", {60'd0, alu_operation, alu_carry_in, alu_binvert}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd("add lo carry", OP_ADD, 64'h00000000_FFFFFFFF, 64'h1,
            64'h00000001_00000000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_cmd("sub 5-7", OP_SUB, 64'd5, 64'd7,
            64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_cmd("sub min-1", OP_SUB, 64'h80000000_00000000, 64'd1,
            64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_cmd("and", OP_AND, 64'hF0F0F0F0_12345678, 64'h0FF00FF0_FFFF0000,
            64'h00F000F0_12340000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_cmd("or", OP_OR, 64'hF0F0F0F0_12345678, 64'h0FF00FF0_FFFF0000,
            64'hFFF0FFF0_FFFF5678, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_cmd("add wrap", OP_ADD, 64'hFFFFFFFF_FFFFFFFF, 64'd1,
            64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 0);

    run_cmd("backpressure", OP_ADD, 64'h00000001_00000010, 64'h00000002_00000020,
            64'h00000003_00000030, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    run_cmd("after release", OP_ADD, 64'd2, 64'd3,
            64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    in_op = OP_ADD; in_a = 64'hFFFF_FFFF; in_b = 64'h1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid-op in HI", {32'd0, alu_a}, 64'd0);
    chk("mid-op hi cin", {63'd0, alu_carry_in}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out_valid/in_ready", {62'd0, out_valid, in_ready}, 64'd0);
    chk("midrst out_result", out_result, 64'd0);
    chk("midrst flags", {61'd0, out_carry, out_zero, out_overflow}, 64'd0);
    chk("midrst alu", {28'd0, alu_operation, alu_carry_in, alu_binvert, alu_a}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_cmd("post-reset add", OP_ADD, 64'd2, 64'd3,
            64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
